// File: rtl/que_rd_stream.sv
// Queue-to-stream reader: pops a registered queue into a 2-entry valid/ready skid buffer with packet framing.
// Optional QUE_RD_STREAM_STATS_EN adds word_cnt/stall_cnt statistics outputs.
module que_rd_stream #(
    parameter int WD    = 32,
    parameter int PKT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             que_empty,
    input  logic [WD-1:0]    que_data,
    output logic             que_pop,
    input  logic             enable,
    input  logic [PKT_W-1:0] pkt_len,
    output logic             m_valid,
    output logic [WD-1:0]    m_data,
    output logic             m_last,
    input  logic             m_ready,
    output logic             busy
`ifdef QUE_RD_STREAM_STATS_EN
    ,
    output logic [31:0]      word_cnt,
    output logic [31:0]      stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t           state_q;
    logic [1:0]       cnt_q, cnt_d;
    logic [WD-1:0]    d0_q, d0_d, d1_q, d1_d;
    logic             l0_q, l0_d, l1_q, l1_d;
    logic [PKT_W-1:0] bcnt_q, bcnt_d, len_q, len_d, len_eff;
    logic             tag_last, xfer;

    assign que_pop = (state_q == RUN) & ~que_empty & (cnt_q < 2'd2);
    assign xfer    = (cnt_q != 2'd0) & m_ready;
    assign m_valid = (cnt_q != 2'd0);
    assign m_data  = d0_q;
    assign m_last  = l0_q;
    assign busy    = (state_q != IDLE);

    // First word of a packet frames itself with the live pkt_len.
    always_comb begin
        len_eff  = (bcnt_q == '0) ? pkt_len : len_q;
        tag_last = (len_eff != '0) && (bcnt_q == len_eff - PKT_W'(1));
        bcnt_d   = bcnt_q;
        len_d    = len_q;
        if (que_pop) begin
            if (bcnt_q == '0)
                len_d = pkt_len;
            if (tag_last || len_eff == '0)
                bcnt_d = '0;
            else
                bcnt_d = bcnt_q + PKT_W'(1);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        d0_d  = d0_q;
        d1_d  = d1_q;
        l0_d  = l0_q;
        l1_d  = l1_q;
        unique case ({que_pop, xfer})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    d0_d = que_data;
                    l0_d = tag_last;
                end else begin
                    d1_d = que_data;
                    l1_d = tag_last;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                d0_d  = d1_q;
                l0_d  = l1_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    d0_d = que_data;
                    l0_d = tag_last;
                end else begin
                    d0_d = d1_q;
                    l0_d = l1_q;
                    d1_d = que_data;
                    l1_d = tag_last;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 2'd0;
            d0_q   <= '0;
            d1_q   <= '0;
            l0_q   <= 1'b0;
            l1_q   <= 1'b0;
            bcnt_q <= '0;
            len_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            d0_q   <= d0_d;
            d1_q   <= d1_d;
            l0_q   <= l0_d;
            l1_q   <= l1_d;
            bcnt_q <= bcnt_d;
            len_q  <= len_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (enable) state_q <= RUN;
                RUN:     if (!enable) state_q <= DRAIN;
                DRAIN: begin
                    if (enable)
                        state_q <= RUN;
                    else if (cnt_q == 2'd0)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef QUE_RD_STREAM_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (que_pop)
                word_cnt <= word_cnt + 32'd1;
            if (m_valid && !m_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_que_rd_stream.sv
// Directed self-checking bench for que_rd_stream with a registered queue model and beat logger.
module tb_que_rd_stream;

    localparam int WD    = 32;
    localparam int PKT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             que_empty;
    logic [WD-1:0]    que_data;
    logic             que_pop;
    logic             enable = 1'b0;
    logic [PKT_W-1:0] pkt_len = '0;
    logic             m_valid;
    logic [WD-1:0]    m_data;
    logic             m_last;
    logic             m_ready = 1'b1;
    logic             busy;
`ifdef QUE_RD_STREAM_STATS_EN
    logic [31:0]      word_cnt;
    logic [31:0]      stall_cnt;
`endif

    que_rd_stream #(.WD(WD), .PKT_W(PKT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .que_empty (que_empty),
        .que_data  (que_data),
        .que_pop   (que_pop),
        .enable    (enable),
        .pkt_len   (pkt_len),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_last    (m_last),
        .m_ready   (m_ready),
`ifdef QUE_RD_STREAM_STATS_EN
        .word_cnt  (word_cnt),
        .stall_cnt (stall_cnt),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Queue model: head advances one cycle after a pop.
    logic [WD-1:0] qmem [0:15];
    int            qbase = 0;
    int            qpops = 0;
    int            qlen  = 0;
    int            qhead;
    logic          tog_en = 1'b0;
    logic          tog_q  = 1'b0;

    always_comb begin
        qhead     = qpops - qbase;
        que_empty = (qhead >= qlen) | tog_q;
        que_data  = (qhead >= 0 && qhead < 16) ? qmem[qhead[3:0]] : '0;
    end

    logic [WD-1:0] bdat [0:255];
    logic          blast [0:255];
    int            bcyc [0:255];
    int            nb = 0;
    int            cyc = 0;
    int            pop_empty_err = 0;
    int            hold_err = 0;
    logic          pv = 1'b0;
    logic [WD-1:0] pd = '0;
    logic          pl = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (que_pop)
            qpops <= qpops + 1;
        tog_q <= tog_en ? ~tog_q : 1'b0;
        if (que_pop && que_empty)
            pop_empty_err <= pop_empty_err + 1;
        if (pv && m_valid && (m_data !== pd || m_last !== pl))
            hold_err <= hold_err + 1;
        pv <= m_valid && !m_ready && rst_n;
        pd <= m_data;
        pl <= m_last;
        if (m_valid && m_ready && nb < 256) begin
            bdat[nb]  <= m_data;
            blast[nb] <= m_last;
            bcyc[nb]  <= cyc;
            nb        <= nb + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic load(input int n, input logic [WD-1:0] first);
        for (int i = 0; i < 16; i++)
            qmem[i] = first + WD'(i);
        qbase = qpops;
        qlen  = n;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_beats(input string tag, input int n, input int lim);
        int k = 0;
        while (nb < n && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 64'(nb >= n), 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 64'(busy), 64'd0);
    endtask

    int b0;
    int p0;
    int k;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_pop", 64'(que_pop), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_data", 64'(m_data), 64'd0);
        chk("rst_last", 64'(m_last), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Eight words, packets of four, full rate
        load(8, 32'h1);
        pkt_len = 16'd4;
        m_ready = 1'b1;
        b0 = nb;
        enable = 1'b1;
        wait_beats("t30_to", b0 + 8, 40);
        enable = 1'b0;
        wait_idle("t30_idle");
        for (int i = 0; i < 8; i++)
            chk("t30_beat", {31'd0, blast[b0+i], bdat[b0+i]},
                {31'd0, (i == 3 || i == 7), WD'(i + 1)});
        chk("t30_b2b", 64'(bcyc[b0+7] - bcyc[b0]), 64'd7);

        // Backpressure for five cycles at beat three
        do_reset();
        load(8, 32'h1);
        pkt_len = 16'd4;
        b0 = nb;
        enable = 1'b1;
        k = 0;
        while (nb < b0 + 2 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("t31_pre", 64'(m_data), 64'h3);
        m_ready = 1'b0;
        repeat (5) @(negedge clk);
        chk("t31_stall_pop", 64'(que_pop), 64'd0);
        chk("t31_stall_data", 64'(m_data), 64'h3);
        chk("t31_stall_valid", 64'(m_valid), 64'd1);
        m_ready = 1'b1;
        wait_beats("t31_to", b0 + 8, 40);
        enable = 1'b0;
        wait_idle("t31_idle");
        for (int i = 0; i < 8; i++)
            chk("t31_beat", {31'd0, blast[b0+i], bdat[b0+i]},
                {31'd0, (i == 3 || i == 7), WD'(i + 1)});
        chk("t31_count", 64'(nb - b0), 64'd8);
`ifdef QUE_RD_STREAM_STATS_EN
        chk("t31_stall_cnt", 64'(stall_cnt), 64'd5);
        chk("t31_word_cnt", 64'(word_cnt), 64'd8);
`endif

        // Unframed stream
        do_reset();
        load(6, 32'h11);
        pkt_len = 16'd0;
        b0 = nb;
        enable = 1'b1;
        wait_beats("t32_to", b0 + 6, 40);
        enable = 1'b0;
        wait_idle("t32_idle");
        for (int i = 0; i < 6; i++)
            chk("t32_beat", {31'd0, blast[b0+i], bdat[b0+i]},
                {31'd0, 1'b0, WD'(32'h11 + i)});
        chk("t32_bcnt", 64'(dut.bcnt_q), 64'd0);

        // Enable drop mid-packet, then resume the same packet
        do_reset();
        load(5, 32'h21);
        pkt_len = 16'd3;
        b0 = nb;
        p0 = qpops;
        enable = 1'b1;
        k = 0;
        while (qpops < p0 + 1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        enable = 1'b0;
        wait_idle("t33_idle");
        chk("t33_pops", 64'(qpops - p0), 64'd2);
        chk("t33_beats", 64'(nb - b0), 64'd2);
        chk("t33_b0", {31'd0, blast[b0], bdat[b0]}, {31'd0, 1'b0, 32'h21});
        chk("t33_b1", {31'd0, blast[b0+1], bdat[b0+1]}, {31'd0, 1'b0, 32'h22});
        pkt_len = 16'd5;
        enable = 1'b1;
        wait_beats("t33_to", b0 + 5, 40);
        enable = 1'b0;
        wait_idle("t33_idle2");
        chk("t33_b2", {31'd0, blast[b0+2], bdat[b0+2]}, {31'd0, 1'b1, 32'h23});
        chk("t33_b3", {31'd0, blast[b0+3], bdat[b0+3]}, {31'd0, 1'b0, 32'h24});
        chk("t33_b4", {31'd0, blast[b0+4], bdat[b0+4]}, {31'd0, 1'b0, 32'h25});

        // Reset with a full buffer
        do_reset();
        load(6, 32'h31);
        pkt_len = 16'd4;
        m_ready = 1'b0;
        enable = 1'b1;
        repeat (4) @(negedge clk);
        chk("t34_full", 64'(dut.cnt_q), 64'd2);
        b0 = nb;
        rst_n = 1'b0;
        #1;
        chk("t34_valid", 64'(m_valid), 64'd0);
        chk("t34_pop", 64'(que_pop), 64'd0);
        chk("t34_busy", 64'(busy), 64'd0);
        chk("t34_data", 64'(m_data), 64'd0);
        chk("t34_last", 64'(m_last), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t34_first_pop", 64'(que_pop), 64'd0);
        m_ready = 1'b1;
        wait_beats("t34_to", b0 + 4, 40);
        enable = 1'b0;
        wait_idle("t34_idle");
        for (int i = 0; i < 4; i++)
            chk("t34_beat", {31'd0, blast[b0+i], bdat[b0+i]},
                {31'd0, (i == 3), WD'(32'h33 + i)});

        // Toggling empty flag
        do_reset();
        load(6, 32'h41);
        pkt_len = 16'd2;
        b0 = nb;
        tog_en = 1'b1;
        enable = 1'b1;
        wait_beats("t35_to", b0 + 6, 60);
        enable = 1'b0;
        tog_en = 1'b0;
        wait_idle("t35_idle");
        for (int i = 0; i < 6; i++)
            chk("t35_beat", {31'd0, blast[b0+i], bdat[b0+i]},
                {31'd0, (i % 2 == 1), WD'(32'h41 + i)});
        chk("t35_pop_empty", 64'(pop_empty_err), 64'd0);
        chk("hold_stable", 64'(hold_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
